// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the console byte UART.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_BITS            = 8;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/byte_uart_tx_if.sv
// ============================================================================
// Module      : byte_uart_tx_if
// Description : Console byte stream in, UART line and buffer status out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface byte_uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [7:0]    in_byte;
    logic          in_valid;
    logic          clear_overflow;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    modport master (
        output in_byte, in_valid, clear_overflow,
        input  tx, busy, overflow, fifo_count
    );

    modport slave (
        input  in_byte, in_valid, clear_overflow,
        output tx, busy, overflow, fifo_count
    );

endinterface : byte_uart_tx_if

`default_nettype wire

// File: rtl/byte_fifo.sv
// ============================================================================
// Module      : byte_fifo
// Description : Byte-wide synchronous FIFO with first-word-fall-through read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_wr_en,
    input  wire logic [DATA_BITS-1:0] i_wr_data,
    input  wire logic                 i_rd_en,
    output logic      [DATA_BITS-1:0] o_rd_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic      [CW-1:0]        o_count
);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    // Storage is not reset; resetting the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

endmodule : byte_fifo

`default_nettype wire

// File: rtl/byte_uart_tx.sv
// ============================================================================
// Module      : byte_uart_tx
// Description : Buffers console bytes and serialises them as 8N1 UART.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  wire logic      clk,
    input  wire logic      reset,
    byte_uart_tx_if.slave  bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [BW-1:0] c_BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] c_LAST_BIT  = IW'(DATA_BITS - 1);

    uart_state_e          r_state;
    logic [BW-1:0]        r_baud;
    logic [IW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_overflow;

    logic [DATA_BITS-1:0] w_fifo_data;
    logic                 w_full;
    logic                 w_empty;
    logic [CW-1:0]        w_count;
    logic                 w_baud_last;
    logic                 w_pop;
    logic                 w_wr_accept;
    logic                 w_drop;

    assign w_baud_last = (r_baud == c_BAUD_LAST);
    assign w_pop       = !w_empty &&
                         ((r_state == IDLE) || ((r_state == STOP) && w_baud_last));
    // A full FIFO still takes a byte when a pop frees a slot on the same edge.
    assign w_wr_accept = bus.in_valid && (!w_full || w_pop);
    assign w_drop      = bus.in_valid && !w_wr_accept;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_wr_accept),
        .i_wr_data (bus.in_byte),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    // tx and busy are registered from the current state, so the line trails
    // the state register by one cycle throughout the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE:    r_tx <= 1'b1;
                START:   r_tx <= 1'b0;
                DATA:    r_tx <= r_shift[0];
                default: r_tx <= 1'b1;
            endcase

            r_busy <= (r_state != IDLE) || !w_empty;

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_overflow) begin
                r_overflow <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    if (!w_empty) begin
                        r_shift <= w_fifo_data;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                DATA: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + IW'(1);
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_shift <= w_fifo_data;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = r_busy;
    assign bus.overflow   = r_overflow;
    assign bus.fifo_count = w_count;

endmodule : byte_uart_tx

`default_nettype wire

// File: tb/tb_byte_uart_tx.sv
// ============================================================================
// Module      : tb_byte_uart_tx
// Description : Randomised self-checking bench for byte_uart_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_byte_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    byte_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    byte_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: a byte queue plus "cycles left in the current frame".
    logic [7:0] q[$];
    logic [7:0] exp_q[$];
    logic [7:0] dec_q[$];
    int         rem   = 0;
    logic [7:0] cur   = '0;
    logic       m_tx  = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_ovf = 1'b0;

    bit         d_act = 1'b0;
    int         d_pos = 0;
    logic [7:0] d_byte = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_q.delete();
        dec_q.delete();
        rem    = 0;
        m_tx   = 1'b1;
        m_busy = 1'b0;
        m_ovf  = 1'b0;
        d_act  = 1'b0;
    endtask

    // Evaluate the edge about to happen from the current (pre-edge) inputs.
    task automatic model_edge();
        int  pos;
        int  bi;
        bit  pop;
        bit  acc;
        if (reset) begin
            model_reset();
            return;
        end
        if (rem == 0) begin
            m_tx = 1'b1;
        end else begin
            pos = FRAME - rem;
            bi  = pos / CPB;
            if (bi == 0)      m_tx = 1'b0;
            else if (bi == 9) m_tx = 1'b1;
            else              m_tx = cur[bi-1];
        end
        m_busy = (rem != 0) || (q.size() != 0);
        pop = (q.size() != 0) && (rem <= 1);
        acc = bus.in_valid && ((q.size() < DEPTH) || pop);
        if (rem > 0) rem--;
        if (pop) begin
            cur = q.pop_front();
            exp_q.push_back(cur);
            rem = FRAME;
        end
        if (bus.in_valid && acc) q.push_back(bus.in_byte);
        if (bus.in_valid && !acc)       m_ovf = 1'b1;
        else if (bus.clear_overflow)    m_ovf = 1'b0;
    endtask

    task automatic decode();
        if (!d_act) begin
            if (bus.tx === 1'b0) begin
                d_act = 1'b1;
                d_pos = 0;
            end
        end else begin
            d_pos++;
            if ((d_pos % CPB) == CPB / 2 && d_pos / CPB >= 1 && d_pos / CPB <= 8)
                d_byte[d_pos/CPB-1] = bus.tx;
            if (d_pos == 9 * CPB + CPB / 2) begin
                chk("stop_bit", {31'd0, bus.tx}, 32'd1);
                dec_q.push_back(d_byte);
            end
            if (d_pos == FRAME - 1) d_act = 1'b0;
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("tx",         {31'd0, bus.tx},       {31'd0, m_tx});
        chk("busy",       {31'd0, bus.busy},     {31'd0, m_busy});
        chk("overflow",   {31'd0, bus.overflow}, {31'd0, m_ovf});
        chk("fifo_count", 32'(bus.fifo_count),   32'(q.size()));
        decode();
    endtask

    task automatic send(input logic [7:0] b, input logic clr);
        bus.in_valid       = 1'b1;
        bus.in_byte        = b;
        bus.clear_overflow = clr;
        step();
        bus.in_valid       = 1'b0;
        bus.clear_overflow = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_decoded(input string tag);
        chk({tag, "_nbytes"}, 32'(dec_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++)
            chk({tag, "_byte"}, {24'd0, dec_q[i]}, {24'd0, exp_q[i]});
        exp_q.delete();
        dec_q.delete();
    endtask

    initial begin
        bus.in_valid       = 1'b1;
        bus.in_byte        = 8'h3C;
        bus.clear_overflow = 1'b0;

        // 1: reset with in_valid held high, then quiet release
        idle(5);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        idle(20);
        check_decoded("reset_idle");

        // 2: single byte
        send(8'h55, 1'b0);
        idle(FRAME + 10);
        check_decoded("single");

        // 3: back-to-back frames
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        send(8'h43, 1'b0);
        idle(3 * FRAME + 10);
        check_decoded("b2b");

        // 4: overflow while idle
        for (int i = 0; i < 6; i++) send(8'(8'h10 + i), 1'b0);
        chk("ovf_count", 32'(bus.fifo_count), 32'd4);
        chk("ovf_flag",  {31'd0, bus.overflow}, 32'd1);
        idle(6 * FRAME);
        check_decoded("overflow");

        // 5: clear alone, then clear coincident with a drop
        bus.clear_overflow = 1'b1;
        step();
        bus.clear_overflow = 1'b0;
        chk("clr_alone", {31'd0, bus.overflow}, 32'd0);
        for (int i = 0; i < 5; i++) send(8'(8'h20 + i), 1'b0);
        send(8'h25, 1'b1);
        chk("clr_vs_drop", {31'd0, bus.overflow}, 32'd1);
        idle(6 * FRAME);
        check_decoded("clr");

        // 6: asynchronous reset during DATA bit 3 with two bytes queued
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b0);
        idle(4 * CPB + 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_tx",    {31'd0, bus.tx},       32'd1);
        chk("async_count", 32'(bus.fifo_count),   32'd0);
        chk("async_busy",  {31'd0, bus.busy},     32'd0);
        model_reset();
        idle(3);
        reset = 1'b0;
        idle(100);
        send(8'hA5, 1'b0);
        idle(FRAME + 10);
        check_decoded("after_reset");

        // 7: random traffic with occasional clears
        for (int i = 0; i < 600; i++) begin
            bus.in_valid       = ($urandom_range(0, 15) < 2);
            bus.in_byte        = 8'($urandom);
            bus.clear_overflow = ($urandom_range(0, 31) == 0);
            step();
        end
        bus.in_valid       = 1'b0;
        bus.clear_overflow = 1'b0;
        idle((DEPTH + 2) * FRAME);
        check_decoded("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_byte_uart_tx

`default_nettype wire
